regfile_wb_arbiter: RTL

- Shares the single register-file write port (wd_addr/wd_data/w_enable) between two writeback requesters: req0 = ALU writeback, req1 = memory-load writeback.
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- The arbiter grants one buffered write per cycle and drives registered write-port signals. Those signals are stable across the negedge, which is when the register file samples them.

---
 rtl/regfile_pkg.sv | 23 ++
 rtl/regfile_wb_arbiter_hold_buf.sv | 48 ++++
 rtl/regfile_wb_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file writeback types and constants
//
// Contents:
//   REG_AW, REG_DW   default register address / data widths
//   REG_ZERO         architectural zero register index
//   wb_req_t         packed {addr, data} writeback request
//   REQ_ALU, REQ_MEM requester indices as reported on grant_id

package regfile_pkg;

    localparam int REG_AW   = 5;
    localparam int REG_DW   = 32;
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_req_t;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;

endpackage

// File: rtl/regfile_wb_arbiter_hold_buf.sv
// rtl/regfile_wb_arbiter_hold_buf.sv - one-entry valid/ready writeback holding register
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     request handshake; transfer when both high on posedge
//   in_addr, in_data      request payload captured on transfer
//   grant                 entry is consumed by the arbiter this cycle
//   clear                 entry is discarded without using the write port
//   full, addr, data      current entry

module wb_hold_buf
    import regfile_pkg::*;
#(
    parameter int AW = REG_AW,
    parameter int DW = REG_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic          grant,
    input  logic          clear,
    output logic          full,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data
);

    // A granted entry leaves on this edge, so the slot can be refilled at once.
    assign in_ready = !full || grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            addr <= '0;
            data <= '0;
        end else if (in_valid && in_ready) begin
            // New accept wins over a same-edge grant: it replaces the granted entry.
            full <= 1'b1;
            addr <= in_addr;
            data <= in_data;
        end else if (grant || clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - two-requester arbiter for the register-file write port
//
// Optional feature macro: REGFILE_WB_ARBITER_FWD_EN (adds write-port bypass outputs)
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req0_valid/addr/data/ready       ALU writeback request (requester 0)
//   req1_valid/addr/data/ready       load writeback request (requester 1)
//   wd_addr, wd_data, w_enable       registered register-file write port
//   grant_id                         requester owning the current w_enable cycle
//   rs_addr, rt_addr                 (FWD_EN) decode-stage read addresses
//   fwd_rs_hit/data, fwd_rt_hit/data (FWD_EN) bypass of the in-flight write
//   idle                             both buffers empty and no write in flight

module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int ARB_MODE   = 0,
    parameter int ZERO_GUARD = 1,
    parameter int DW         = REG_DW,
    parameter int AW         = REG_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] wd_addr,
    output logic [DW-1:0] wd_data,
    output logic          w_enable,
    output logic          grant_id,
`ifdef REGFILE_WB_ARBITER_FWD_EN
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic          fwd_rs_hit,
    output logic          fwd_rt_hit,
    output logic [DW-1:0] fwd_rs_data,
    output logic [DW-1:0] fwd_rt_data,
`endif
    output logic          idle
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);
    localparam bit GUARD_ON = (ZERO_GUARD != 0);
    localparam bit FIXED_PRI = (ARB_MODE == 1);

    logic          full0, full1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] data0, data1;
    logic          grant0, grant1;
    logic          clear0, clear1;
    logic          elig0, elig1;
    // Round-robin pointer: 1 means req1 is preferred on the next contention.
    logic          rr_ptr;

    wb_hold_buf #(.AW(AW), .DW(DW)) u_buf0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (req0_valid),
        .in_addr  (req0_addr),
        .in_data  (req0_data),
        .in_ready (req0_ready),
        .grant    (grant0),
        .clear    (clear0),
        .full     (full0),
        .addr     (addr0),
        .data     (data0)
    );

    wb_hold_buf #(.AW(AW), .DW(DW)) u_buf1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (req1_valid),
        .in_addr  (req1_addr),
        .in_data  (req1_data),
        .in_ready (req1_ready),
        .grant    (grant1),
        .clear    (clear1),
        .full     (full1),
        .addr     (addr1),
        .data     (data1)
    );

    // Writes to the zero register are dropped in place and never compete for
    // the port, so the other buffer can still be granted on the same edge.
    always_comb begin
        clear0 = full0 && GUARD_ON && (addr0 == ZERO_ADDR);
        clear1 = full1 && GUARD_ON && (addr1 == ZERO_ADDR);
        elig0  = full0 && !clear0;
        elig1  = full1 && !clear1;
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (elig0 && elig1) begin
            if (FIXED_PRI || !rr_ptr) begin
                grant0 = 1'b1;
            end else begin
                grant1 = 1'b1;
            end
        end else begin
            grant0 = elig0;
            grant1 = elig1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (grant0) begin
            rr_ptr <= 1'b1;
        end else if (grant1) begin
            rr_ptr <= 1'b0;
        end
    end

    // Registered port: stable through the negedge where the register file samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_enable <= 1'b0;
            wd_addr  <= '0;
            wd_data  <= '0;
            grant_id <= REQ_ALU;
        end else if (grant0 || grant1) begin
            w_enable <= 1'b1;
            wd_addr  <= grant1 ? addr1 : addr0;
            wd_data  <= grant1 ? data1 : data0;
            grant_id <= grant1 ? REQ_MEM : REQ_ALU;
        end else begin
            w_enable <= 1'b0;
        end
    end

    assign idle = !full0 && !full1 && !w_enable;

`ifdef REGFILE_WB_ARBITER_FWD_EN
    logic port_live;

    assign port_live   = w_enable && (wd_addr != ZERO_ADDR || !GUARD_ON);
    assign fwd_rs_hit  = port_live && (wd_addr == rs_addr);
    assign fwd_rt_hit  = port_live && (wd_addr == rt_addr);
    assign fwd_rs_data = wd_data;
    assign fwd_rt_data = wd_data;
`endif

endmodule
